// File: rtl/mem_bridge.sv
// mem_bridge: SoC bus bridge to BIOS ROM, work RAM, I/O window and cartridge.
// Optional feature: define MEM_BRIDGE_CART_TIMEOUT_EN to bound cartridge waits
// to CART_TIMEOUT cycles; otherwise CART_REQ waits for cart_ack indefinitely.
//
// state      | meaning
// S_IDLE     | nothing in flight
// S_LOCAL    | one-cycle BIOS/RAM/I/O/unmapped access
// S_CART_REQ | cartridge request held, waiting for cart_ack (or timeout)
// S_DONE     | one-cycle cartridge completion, cart_req low
module mem_bridge #(
    parameter int CART_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] address_in,
    input  logic [7:0]  data_in,
    input  logic [1:0]  bus_status,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  data_out,
    output logic [11:0] bios_addr,
    input  logic [7:0]  bios_q,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic        cart_req,
    output logic [20:0] cart_addr,
    output logic        cart_we,
    output logic [7:0]  cart_wdata,
    input  logic        cart_ack,
    input  logic [7:0]  cart_rdata,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);
    // bus_status code the CPU drives for IRQ vector fetches; such strobes are not ours
    localparam logic [1:0] BUS_IRQ_READ = 2'b11;

    localparam logic [2:0] T_BIOS = 3'd0, T_RAM = 3'd1, T_IO = 3'd2, T_CART = 3'd3, T_UNMAP = 3'd4;
    // deferred data_out source: sync ROM/RAM data arrives one cycle after LOCAL
    localparam logic [1:0] LD_NONE = 2'd0, LD_BIOS = 2'd1, LD_RAM = 2'd2, LD_OPEN = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_LOCAL, S_CART_REQ, S_DONE} state_t;

    function automatic logic [2:0] decode(input logic [23:0] a);
        if (a < 24'h001000)      return T_BIOS;
        else if (a < 24'h002000) return T_RAM;
        else if (a < 24'h002100) return T_IO;
        else if (a < 24'h200000) return T_CART;
        else                     return T_UNMAP;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] cur_addr_q, cur_addr_d;
    logic [7:0]  cur_data_q, cur_data_d;
    logic        cur_we_q, cur_we_d;
    logic        slot_vld_q, slot_vld_d;
    logic [23:0] slot_addr_q, slot_addr_d;
    logic [7:0]  slot_data_q, slot_data_d;
    logic        slot_we_q, slot_we_d;
    logic [1:0]  ld_sel_q, ld_sel_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        overrun_q, overrun_d;
    logic        accept;
    logic        tmo_exp;
    logic [2:0]  cur_tgt;

    assign accept  = (read | write) & (bus_status != BUS_IRQ_READ);
    assign cur_tgt = decode(cur_addr_q);

`ifdef MEM_BRIDGE_CART_TIMEOUT_EN
    localparam int TW = $clog2(CART_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    // down-counter reloads outside CART_REQ and expires at terminal count 0
    always_comb begin
        tmo_cnt_d = TW'(CART_TIMEOUT - 1);
        if (state_q == S_CART_REQ) tmo_cnt_d = tmo_cnt_q - TW'(1);
        tmo_exp   = (state_q == S_CART_REQ) && (tmo_cnt_q == '0);
        timeout_d = timeout_q | (tmo_exp & ~cart_ack);
    end

    // timeout counter and sticky flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= TW'(CART_TIMEOUT - 1);
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_exp = 1'b0;
    assign timeout = 1'b0;
`endif

    // next-state, issue/slot management and data_out update
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        cur_we_d    = cur_we_q;
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        slot_we_d   = slot_we_q;
        ld_sel_d    = LD_NONE;
        data_out_d  = data_out_q;
        overrun_d   = overrun_q;

        case (ld_sel_q)
            LD_BIOS: data_out_d = bios_q;
            LD_RAM:  data_out_d = ram_q;
            LD_OPEN: data_out_d = 8'hFF;
            default: ;
        endcase

        if (state_q == S_LOCAL && !cur_we_q) begin
            case (cur_tgt)
                T_BIOS:  ld_sel_d = LD_BIOS;
                T_RAM:   ld_sel_d = LD_RAM;
                default: ld_sel_d = LD_OPEN;
            endcase
        end

        if (state_q == S_CART_REQ) begin
            // cartridge data is newer than any deferred local load, so it wins
            if (cart_ack || tmo_exp) begin
                state_d = S_DONE;
                if (!cur_we_q) data_out_d = cart_ack ? cart_rdata : 8'hFF;
            end
            if (accept) begin
                if (slot_vld_q) begin
                    overrun_d = 1'b1;
                end else begin
                    slot_vld_d  = 1'b1;
                    slot_addr_d = address_in;
                    slot_data_d = data_in;
                    slot_we_d   = write;
                end
            end
        end else begin
            // IDLE, or LOCAL/DONE completing this cycle: issue slot first, else the new strobe
            state_d = S_IDLE;
            if (slot_vld_q) begin
                cur_addr_d  = slot_addr_q;
                cur_data_d  = slot_data_q;
                cur_we_d    = slot_we_q;
                state_d     = (decode(slot_addr_q) == T_CART) ? S_CART_REQ : S_LOCAL;
                slot_vld_d  = accept;
                slot_addr_d = address_in;
                slot_data_d = data_in;
                slot_we_d   = write;
            end else if (accept) begin
                cur_addr_d = address_in;
                cur_data_d = data_in;
                cur_we_d   = write;
                state_d    = (decode(address_in) == T_CART) ? S_CART_REQ : S_LOCAL;
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            cur_we_q    <= 1'b0;
            slot_vld_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            slot_we_q   <= 1'b0;
            ld_sel_q    <= LD_NONE;
            data_out_q  <= 8'hFF;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            cur_we_q    <= cur_we_d;
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            slot_we_q   <= slot_we_d;
            ld_sel_q    <= ld_sel_d;
            data_out_q  <= data_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign bios_addr  = cur_addr_q[11:0];
    assign ram_addr   = cur_addr_q[11:0];
    assign ram_wdata  = cur_data_q;
    assign ram_we     = (state_q == S_LOCAL) && cur_we_q && (cur_tgt == T_RAM);
    assign cart_req   = (state_q == S_CART_REQ);
    assign cart_addr  = cur_addr_q[20:0];
    assign cart_we    = cart_req & cur_we_q;
    assign cart_wdata = cur_data_q;
    assign busy       = (state_q != S_IDLE) | slot_vld_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: vector table for single local accesses,
// hand sequences for cartridge, pending-slot, overrun, timeout and reset cases.
module tb_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] address_in;
    logic [7:0]  data_in;
    logic [1:0]  bus_status;
    logic        read, write;
    logic [7:0]  data_out;
    logic [11:0] bios_addr;
    logic [7:0]  bios_q;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic        cart_req;
    logic [20:0] cart_addr;
    logic        cart_we;
    logic [7:0]  cart_wdata;
    logic        cart_ack;
    logic [7:0]  cart_rdata;
    logic        busy, overrun, timeout;

    always #5 clk = ~clk;

    mem_bridge dut (
        .clk(clk), .reset(reset), .address_in(address_in), .data_in(data_in),
        .bus_status(bus_status), .read(read), .write(write), .data_out(data_out),
        .bios_addr(bios_addr), .bios_q(bios_q), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q),
        .cart_req(cart_req), .cart_addr(cart_addr), .cart_we(cart_we),
        .cart_wdata(cart_wdata), .cart_ack(cart_ack), .cart_rdata(cart_rdata),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ROM content chosen so address 0x010 holds 0x5A
    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return a[7:0] ^ 8'h4A;
    endfunction

    always @(posedge clk) bios_q <= rom_f(bios_addr);

    logic [7:0] ram_mem [0:4095];
    initial for (int i = 0; i < 4096; i++) ram_mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_q <= ram_mem[ram_addr];
    end

    // cartridge responder: ack in the cart_delay-th request cycle
    logic       resp_en = 1'b0;
    logic       resp_ack = 1'b0;
    logic [7:0] resp_rdata = 8'h00;
    logic       man_ack = 1'b0;
    int         cart_delay = 1;
    logic [7:0] cart_val = 8'h00;
    int         cart_cnt = 0;

    assign cart_ack   = resp_ack | man_ack;
    assign cart_rdata = man_ack ? 8'h99 : resp_rdata;

    always @(negedge clk) begin
        if (resp_en && cart_req && !resp_ack) begin
            cart_cnt = cart_cnt + 1;
            if (cart_cnt == cart_delay) begin
                resp_ack   = 1'b1;
                resp_rdata = cart_val;
            end
        end else begin
            resp_ack = 1'b0;
            cart_cnt = 0;
        end
    end

    // scoreboard: expected data_out values with the cycle they must appear in
    typedef struct {
        int         due;
        logic [7:0] val;
        string      tag;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;

    task automatic sb_push(input int due, input logic [7:0] val, input string tag);
        sb_t e;
        e.due = due; e.val = val; e.tag = tag;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                mon_e = sbq.pop_front();
                chk(mon_e.tag, data_out, mon_e.val);
            end
        end
    end

    task automatic drive(input logic [23:0] a, input logic [7:0] d, input logic rd,
                         input logic wr, input logic [1:0] st);
        address_in = a; data_in = d; read = rd; write = wr; bus_status = st;
    endtask

    task automatic quiet();
        read = 1'b0; write = 1'b0; bus_status = 2'b00;
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic [1:0]  st;
        logic        acc;
        logic        exp_we;
        logic [7:0]  exp_rd;
    } vec_t;
    localparam int NV = 15;
    vec_t vt [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        vt[0]  = '{24'h000010, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 8'h5A};
        vt[1]  = '{24'h001234, 8'hC3, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00};
        vt[2]  = '{24'h001234, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 8'hC3};
        vt[3]  = '{24'h000FFF, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 8'hB5};
        vt[4]  = '{24'h001FFF, 8'h3C, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00};
        vt[5]  = '{24'h001FFF, 8'h00, 1'b0, 2'b10, 1'b1, 1'b0, 8'h3C};
        vt[6]  = '{24'h002000, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 8'hFF};
        vt[7]  = '{24'h0020FF, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 8'hFF};
        vt[8]  = '{24'h000020, 8'h11, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00};
        vt[9]  = '{24'h200000, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 8'hFF};
        vt[10] = '{24'h002050, 8'h77, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00};
        vt[11] = '{24'h001000, 8'hA7, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00};
        vt[12] = '{24'h001000, 8'h99, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00};
        vt[13] = '{24'h001000, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA7};
        vt[14] = '{24'h000010, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00};

        reset = 1'b0;
        drive(24'h0, 8'h0, 1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cart_req", cart_req, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_cart_addr", cart_addr, 21'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single local accesses from the vector table
        for (int i = 0; i < NV; i++) begin
            s = cyc + 1;
            drive(vt[i].addr, vt[i].wdata, !vt[i].wr, vt[i].wr, vt[i].st);
            if (vt[i].acc && !vt[i].wr) sb_push(s + 2, vt[i].exp_rd, "vec_rd");
            @(negedge clk);
            quiet();
            chk("vec_busy", busy, vt[i].acc);
            chk("vec_ram_we", ram_we, vt[i].exp_we);
            if (vt[i].acc) chk("vec_addr", bios_addr, vt[i].addr[11:0]);
            if (vt[i].exp_we) chk("vec_wdata", ram_wdata, vt[i].wdata);
            @(negedge clk);
            chk("vec_busy_end", busy, 1'b0);
            chk("vec_we_end", ram_we, 1'b0);
            repeat (2) @(negedge clk);
        end

        // two local reads on consecutive cycles: second issues directly at completion
        s = cyc + 1;
        drive(24'h000010, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 2, 8'h5A, "b2b_rd0");
        @(negedge clk);
        drive(24'h001234, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 3, 8'hC3, "b2b_rd1");
        chk("b2b_bios_addr", bios_addr, 12'h010);
        @(negedge clk);
        quiet();
        chk("b2b_ram_addr", ram_addr, 12'h234);
        chk("b2b_busy", busy, 1'b1);
        @(negedge clk);
        chk("b2b_idle", busy, 1'b0);
        repeat (3) @(negedge clk);

        // cartridge read, ack in the 3rd request cycle
        resp_en = 1'b1; cart_delay = 3; cart_val = 8'h77;
        s = cyc + 1;
        drive(24'h012345, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 3, 8'h77, "cart_rd");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            quiet();
            chk("cart_req_held", cart_req, 1'b1);
            chk("cart_addr_held", cart_addr, 21'h012345);
        end
        @(negedge clk);
        chk("cart_done_req", cart_req, 1'b0);
        chk("cart_done_busy", busy, 1'b1);
        @(negedge clk);
        chk("cart_idle", busy, 1'b0);
        repeat (2) @(negedge clk);

        // cartridge write at top of window
        cart_delay = 2;
        drive(24'h1FFFFF, 8'h5E, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        quiet();
        chk("cwr_req", cart_req, 1'b1);
        chk("cwr_we", cart_we, 1'b1);
        chk("cwr_wdata", cart_wdata, 8'h5E);
        chk("cwr_addr", cart_addr, 21'h1FFFFF);
        @(negedge clk);
        chk("cwr_we_held", cart_we, 1'b1);
        @(negedge clk);
        chk("cwr_done_we", cart_we, 1'b0);
        chk("cwr_done_req", cart_req, 1'b0);
        @(negedge clk);
        chk("cwr_keep_data", data_out, 8'h77);
        repeat (2) @(negedge clk);

        // first cartridge address, one-cycle ack
        cart_delay = 1; cart_val = 8'h31;
        s = cyc + 1;
        drive(24'h002100, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 1, 8'h31, "cart_lo_rd");
        @(negedge clk);
        quiet();
        chk("cart_lo_req", cart_req, 1'b1);
        chk("cart_lo_addr", cart_addr, 21'h002100);
        repeat (3) @(negedge clk);

        // completion with slot full and a new strobe: slot issues, strobe refills slot
        cart_delay = 2; cart_val = 8'h66;
        s = cyc + 1;
        drive(24'h003000, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 2, 8'h66, "cc_cart_rd");
        @(negedge clk);
        drive(24'h000020, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 5, 8'h6A, "cc_bios_rd");
        @(negedge clk);
        quiet();
        chk("cc_busy", busy, 1'b1);
        chk("cc_req", cart_req, 1'b1);
        @(negedge clk);
        drive(24'h001234, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 6, 8'hC3, "cc_ram_rd");
        chk("cc_done_req", cart_req, 1'b0);
        @(negedge clk);
        quiet();
        chk("cc_bios_addr", bios_addr, 12'h020);
        chk("cc_no_overrun", overrun, 1'b0);
        @(negedge clk);
        chk("cc_ram_addr", ram_addr, 12'h234);
        chk("cc_busy2", busy, 1'b1);
        @(negedge clk);
        chk("cc_idle", busy, 1'b0);
        chk("cc_no_overrun2", overrun, 1'b0);
        repeat (3) @(negedge clk);

        // three strobes in a row during a cartridge access: 2nd queued, 3rd dropped
        cart_delay = 4; cart_val = 8'h42;
        s = cyc + 1;
        drive(24'h100000, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 4, 8'h42, "ov_cart_rd");
        @(negedge clk);
        drive(24'h000010, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 7, 8'h5A, "ov_bios_rd");
        @(negedge clk);
        drive(24'h001234, 8'h0, 1'b1, 1'b0, 2'b00);
        chk("ov_before", overrun, 1'b0);
        @(negedge clk);
        quiet();
        chk("ov_set", overrun, 1'b1);
        chk("ov_busy", busy, 1'b1);
        @(negedge clk);
        chk("ov_req", cart_req, 1'b1);
        @(negedge clk);
        chk("ov_done_req", cart_req, 1'b0);
        chk("ov_done_busy", busy, 1'b1);
        @(negedge clk);
        chk("ov_issue_addr", bios_addr, 12'h010);
        chk("ov_issue_busy", busy, 1'b1);
        @(negedge clk);
        chk("ov_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("ov_sticky", overrun, 1'b1);
        resp_en = 1'b0;

`ifdef MEM_BRIDGE_CART_TIMEOUT_EN
        // no ack: request released after 15 cycles, open-bus data, sticky timeout
        s = cyc + 1;
        drive(24'h060000, 8'h0, 1'b1, 1'b0, 2'b00);
        sb_push(s + 15, 8'hFF, "tmo_rd");
        @(negedge clk);
        quiet();
        repeat (14) @(negedge clk);
        chk("tmo_req_last", cart_req, 1'b1);
        chk("tmo_not_yet", timeout, 1'b0);
        @(negedge clk);
        chk("tmo_req_drop", cart_req, 1'b0);
        chk("tmo_set", timeout, 1'b1);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", timeout, 1'b1);
`endif

        // reset during CART_REQ, then a late ack
        drive(24'h050000, 8'h0, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        quiet();
`ifdef MEM_BRIDGE_CART_TIMEOUT_EN
        repeat (2) @(negedge clk);
        chk("rr_req", cart_req, 1'b1);
`else
        repeat (20) @(negedge clk);
        chk("rr_wait_req", cart_req, 1'b1);
        chk("rr_no_timeout", timeout, 1'b0);
`endif
        #2 reset = 1'b0;
        #1;
        chk("rr_req_async", cart_req, 1'b0);
        chk("rr_busy", busy, 1'b0);
        chk("rr_data", data_out, 8'hFF);
        chk("rr_overrun", overrun, 1'b0);
        chk("rr_timeout", timeout, 1'b0);
        chk("rr_bios_addr", bios_addr, 12'h0);
        chk("rr_ram_addr", ram_addr, 12'h0);
        chk("rr_cart_addr", cart_addr, 21'h0);
        chk("rr_cart_we", cart_we, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("late_req", cart_req, 1'b0);
        chk("late_data", data_out, 8'hFF);
        chk("late_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        chk("late_data2", data_out, 8'hFF);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning), one per line:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- address_in  in  24  SoC bus address (address_out of the SoC top)
- data_in  in  8  SoC bus write data
- bus_status  in  2  SoC bus command code
- read  in  1  read strobe, one cycle
- write  in  1  write strobe, one cycle
- data_out  out  8  read data returned to the SoC data_in
- bios_addr  out  12  BIOS ROM address (sync ROM, 1-cycle latency)
- bios_q  in  8  BIOS ROM data
- ram_addr  out  12  work RAM address (sync RAM, 1-cycle latency)
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM data
- cart_req  out  1  cartridge request, held until ack
- cart_addr  out  21  cartridge byte address
- cart_we  out  1  cartridge write qualifier
- cart_wdata  out  8  cartridge write data
- cart_ack  in  1  cartridge done, one cycle
- cart_rdata  in  8  cartridge read data, valid with cart_ack
- busy  out  1  access in flight or pending
- overrun  out  1  sticky: strobe dropped
- timeout  out  1  sticky: cartridge timed out
REQ-003 Parameter CART_TIMEOUT, default 15: cartridge wait limit in cycles.

Function
REQ-004 Decode: 0x000000-0x000FFF BIOS; 0x001000-0x001FFF RAM; 0x002000-0x0020FF I/O; 0x002100-0x1FFFFF cartridge (cart_addr = address_in[20:0]); at or above 0x200000 unmapped.
REQ-005 Accept: at a posedge with read or write high and bus_status not equal to the CPU IRQ-read code; strobes carrying the IRQ-read code are ignored entirely.
REQ-006 FSM states: IDLE, LOCAL, CART_REQ, DONE.
REQ-007 BIOS/RAM access: IDLE->LOCAL->IDLE; data_out is registered from bios_q/ram_q exactly 2 cycles after the strobe and held until the next completed read.
REQ-008 RAM write: ram_we high for exactly one cycle (the LOCAL cycle), with ram_addr and ram_wdata stable.
REQ-009 BIOS write, I/O write, unmapped write: no side effect, 1-cycle LOCAL pass.
REQ-010 I/O read and unmapped read: data_out = 0xFF (open bus).
REQ-011 Cartridge access: IDLE->CART_REQ. cart_req, cart_addr, cart_we and cart_wdata are held until the cart_ack cycle. On ack, a read loads cart_rdata into data_out. State then passes through DONE (1 cycle) to IDLE; cart_req drops in DONE.
REQ-012 Pending slot: a strobe accepted while busy is latched (address, data, direction) into a one-deep slot and issued on the cycle after DONE/LOCAL completes, with no IDLE bubble.
REQ-013 If a strobe arrives while the slot is full, it is dropped and overrun is set.
REQ-014 Simultaneous completion and new strobe in the same cycle: the new strobe enters the slot; no overrun.
REQ-015 busy = (state != IDLE) | slot valid.
REQ-016 overrun and timeout are sticky and are cleared only by reset.

Reset
REQ-017 While reset is low: state IDLE, slot empty, data_out=0xFF, cart_req=0, cart_we=0, ram_we=0, busy=0, overrun=0, timeout=0, and all address outputs 0.
REQ-018 Reset asserted mid-cartridge-access: cart_req drops asynchronously and the access is abandoned; a late cart_ack is ignored.

Configuration
REQ-019 Macro MEM_BRIDGE_CART_TIMEOUT_EN, when defined: a counter runs in CART_REQ. If CART_TIMEOUT cycles elapse without cart_ack, cart_req is released, a read returns 0xFF, timeout is set, and the FSM goes to DONE.
REQ-020 When MEM_BRIDGE_CART_TIMEOUT_EN is not defined: CART_REQ waits indefinitely, no counter is synthesized, and timeout is tied to 0.

Verification
REQ-021 BIOS read 0x000010 with bios_q=0x5A -> bios_addr=0x010; data_out=0x5A two cycles after the strobe; busy high for 1 cycle.
REQ-022 RAM write 0x001234 data 0xC3, then read same address -> ram_we pulses once with ram_addr=0x234 and ram_wdata=0xC3; the read returns ram_q.
REQ-023 Cartridge read 0x012345, cart_ack after 3 cycles with 0x77 -> cart_addr=0x012345 held 3 cycles; data_out=0x77; cart_req low in DONE.
REQ-024 Three strobes on consecutive cycles during a cartridge access -> the 2nd is queued and issued back-to-back; the 3rd is dropped; overrun=1.
REQ-025 With MEM_BRIDGE_CART_TIMEOUT_EN defined and no ack -> cart_req released after 15 cycles; data_out=0xFF; timeout=1 until reset.
REQ-026 Reset pulsed low during CART_REQ, then a late cart_ack -> all outputs at reset values; data_out stays 0xFF.
